filter_frame_arbiter: RTL and testbench

- Shares one window filter (sobel or gaussian) between two independent pixel sources, with frame-granularity round-robin arbitration.
- Sits between two source FIFOs and the filter's input FIFO. Returns each filtered frame to the destination FIFO of the source that produced it.
- Frame ownership is carried through the filter latency by a small tag FIFO. The filter itself is unmodified and sees one continuous stream of whole frames.

---
 rtl/filter_frame_arbiter.sv | 156 +++++++++++++++
 tb/tb_filter_frame_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_frame_arbiter.sv
// rtl/filter_frame_arbiter.sv - frame-granularity round-robin sharing of one window filter between two pixel sources
// Optional per-destination frame counters are enabled by FILTER_FRAME_ARB_STATS_EN.

module filter_frame_arbiter #(
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  src0_rd_en,
  input  logic [DWIDTH_IN-1:0]  src0_dout,
  input  logic                  src0_empty,
  output logic                  src1_rd_en,
  input  logic [DWIDTH_IN-1:0]  src1_dout,
  input  logic                  src1_empty,
  output logic                  flt_in_wr_en,
  output logic [DWIDTH_IN-1:0]  flt_in_din,
  input  logic                  flt_in_full,
  output logic                  flt_out_rd_en,
  input  logic [DWIDTH_OUT-1:0] flt_out_dout,
  input  logic                  flt_out_empty,
  output logic                  dst0_wr_en,
  output logic [DWIDTH_OUT-1:0] dst0_din,
  input  logic                  dst0_full,
  output logic                  dst1_wr_en,
  output logic [DWIDTH_OUT-1:0] dst1_din,
  input  logic                  dst1_full,
  output logic                  busy,
`ifdef FILTER_FRAME_ARB_STATS_EN
  output logic [15:0]           frames_done0,
  output logic [15:0]           frames_done1,
  output logic                  cur_src
`else
  output logic                  cur_src
`endif
);

  localparam int PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int AW     = $clog2(TAG_DEPTH);
  localparam int PW     = AW + 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(PIXELS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_q;
  logic                 cur_src_q;
  logic                 last_served_q;
  logic [CW-1:0]        in_count_q;
  logic [CW-1:0]        out_count_q;
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [TAG_DEPTH-1:0] tag_mem_q;

  logic tag_empty, tag_full, grant_valid, grant_src;
  logic in_xfer, head, head_full, out_xfer, tag_pop;

  always_comb begin
    tag_empty   = (wr_ptr_q == rd_ptr_q);
    tag_full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    grant_valid = (state_q == IDLE) && !tag_full && (!src0_empty || !src1_empty);
    // A lone requester wins outright; on a tie the source not served last wins.
    grant_src   = (!src0_empty && !src1_empty) ? ~last_served_q : src0_empty;
    in_xfer     = (state_q == STREAM) && !(cur_src_q ? src1_empty : src0_empty) && !flt_in_full;
    head        = tag_mem_q[rd_ptr_q[AW-1:0]];
    head_full   = head ? dst1_full : dst0_full;
    out_xfer    = !tag_empty && !flt_out_empty && !head_full;
    tag_pop     = out_xfer && (out_count_q == LAST_PIX);
  end

  assign src0_rd_en    = in_xfer & ~cur_src_q;
  assign src1_rd_en    = in_xfer & cur_src_q;
  assign flt_in_wr_en  = in_xfer;
  assign flt_in_din    = !in_xfer ? '0 : (cur_src_q ? src1_dout : src0_dout);
  assign flt_out_rd_en = out_xfer;
  assign dst0_wr_en    = out_xfer & ~head;
  assign dst1_wr_en    = out_xfer & head;
  assign dst0_din      = dst0_wr_en ? flt_out_dout : '0;
  assign dst1_din      = dst1_wr_en ? flt_out_dout : '0;
  assign busy          = (state_q == STREAM) || !tag_empty;
  assign cur_src       = cur_src_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_src_q     <= 1'b0;
      last_served_q <= 1'b1;
      in_count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            cur_src_q  <= grant_src;
            in_count_q <= '0;
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (in_xfer) begin
            in_count_q <= in_count_q + CW'(1);
            if (in_count_q == LAST_PIX) begin
              last_served_q <= cur_src_q;
              state_q       <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag FIFO carries frame ownership across the filter latency; the output side is independent of the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_count_q <= '0;
      tag_mem_q   <= '0;
    end else begin
      if (grant_valid) begin
        tag_mem_q[wr_ptr_q[AW-1:0]] <= grant_src;
        wr_ptr_q                    <= wr_ptr_q + PW'(1);
      end
      if (out_xfer) begin
        out_count_q <= tag_pop ? '0 : out_count_q + CW'(1);
      end
      if (tag_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

`ifdef FILTER_FRAME_ARB_STATS_EN
  logic [15:0] done0_q, done1_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done0_q <= '0;
      done1_q <= '0;
    end else if (tag_pop) begin
      if (head) begin
        done1_q <= done1_q + 16'd1;
      end else begin
        done0_q <= done0_q + 16'd1;
      end
    end
  end

  assign frames_done0 = done0_q;
  assign frames_done1 = done1_q;
`endif

endmodule

// File: tb/tb_filter_frame_arbiter.sv
// tb/tb_filter_frame_arbiter.sv - scoreboard bench for filter_frame_arbiter with an identity-FIFO filter model

module tb_filter_frame_arbiter;

  localparam int NP = 12;

  logic       clock = 1'b0;
  logic       reset;
  logic       src0_rd_en, src1_rd_en, src0_empty, src1_empty;
  logic [7:0] src0_dout, src1_dout;
  logic       flt_in_wr_en, flt_in_full, flt_out_rd_en, flt_out_empty;
  logic [7:0] flt_in_din, flt_out_dout;
  logic       dst0_wr_en, dst1_wr_en, dst0_full, dst1_full;
  logic [7:0] dst0_din, dst1_din;
  logic       busy, cur_src;
`ifdef FILTER_FRAME_ARB_STATS_EN
  logic [15:0] frames_done0, frames_done1;
`endif

  filter_frame_arbiter #(
    .DWIDTH_IN(8), .DWIDTH_OUT(8), .IMG_WIDTH(4), .IMG_HEIGHT(3), .TAG_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .src0_rd_en(src0_rd_en), .src0_dout(src0_dout), .src0_empty(src0_empty),
    .src1_rd_en(src1_rd_en), .src1_dout(src1_dout), .src1_empty(src1_empty),
    .flt_in_wr_en(flt_in_wr_en), .flt_in_din(flt_in_din), .flt_in_full(flt_in_full),
    .flt_out_rd_en(flt_out_rd_en), .flt_out_dout(flt_out_dout), .flt_out_empty(flt_out_empty),
    .dst0_wr_en(dst0_wr_en), .dst0_din(dst0_din), .dst0_full(dst0_full),
    .dst1_wr_en(dst1_wr_en), .dst1_din(dst1_din), .dst1_full(dst1_full),
    .busy(busy),
`ifdef FILTER_FRAME_ARB_STATS_EN
    .frames_done0(frames_done0), .frames_done1(frames_done1),
`endif
    .cur_src(cur_src)
  );

  always #5 clock = ~clock;

  logic [7:0] sq0[$], sq1[$], fq[$], exp0[$], exp1[$];
  int frame_src_log[$];
  int checks = 0, errors = 0;
  int cyc = 0, fcap = 64;
  int in_pix = 0, cur_fsrc = 0, rx0 = 0, rx1 = 0;
  int last_wr_cyc = 0, pop_cyc = -1, g5_cyc = -1, fifo_hit_full = 0;
  int s;
  logic [7:0] hd;

  typedef struct {
    int f0;
    int f1;
    int exp_rx0;
    int exp_rx1;
    int exp_first;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  task automatic score(input int d, input logic [7:0] v);
    if (d == 0) begin
      if (exp0.size() == 0) fail_now("dst0_extra_pixel");
      else chk("dst0_data", v, exp0.pop_front());
      rx0++;
      if (rx0 == NP && pop_cyc < 0) pop_cyc = cyc;
    end else begin
      if (exp1.size() == 0) fail_now("dst1_extra_pixel");
      else chk("dst1_data", v, exp1.pop_front());
      rx1++;
    end
    last_wr_cyc = cyc;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    src0_empty    = (sq0.size() == 0);
    src0_dout     = (sq0.size() != 0) ? sq0[0] : 8'h00;
    src1_empty    = (sq1.size() == 0);
    src1_dout     = (sq1.size() != 0) ? sq1[0] : 8'h00;
    flt_in_full   = (fq.size() >= fcap);
    flt_out_empty = (fq.size() == 0);
    flt_out_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
  end

  // Output side first so a pixel pushed this cycle can never be popped in the same cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (fq.size() >= fcap) fifo_hit_full = 1;
      chk("flt_out_rd_vs_dst", flt_out_rd_en, dst0_wr_en | dst1_wr_en);
      chk("dst_both_wr", dst0_wr_en & dst1_wr_en, 0);
      if (flt_out_rd_en) begin
        if (fq.size() == 0) fail_now("flt_out_underflow");
        else begin
          hd = fq.pop_front();
          if (dst0_wr_en) begin
            chk("dst0_din_pass", dst0_din, hd);
            chk("dst0_wr_while_full", dst0_full, 0);
            chk("dst1_din_idle", dst1_din, 0);
            score(0, dst0_din);
          end else if (dst1_wr_en) begin
            chk("dst1_din_pass", dst1_din, hd);
            chk("dst1_wr_while_full", dst1_full, 0);
            chk("dst0_din_idle", dst0_din, 0);
            score(1, dst1_din);
          end
        end
      end else begin
        chk("dst0_din_idle", dst0_din, 0);
        chk("dst1_din_idle", dst1_din, 0);
      end
      chk("flt_in_vs_src", flt_in_wr_en, src0_rd_en | src1_rd_en);
      chk("src_both_rd", src0_rd_en & src1_rd_en, 0);
      if (flt_in_wr_en) begin
        s = src1_rd_en ? 1 : 0;
        if (s == 1 && sq1.size() == 0) fail_now("src1_underflow");
        else if (s == 0 && sq0.size() == 0) fail_now("src0_underflow");
        else begin
          if (s == 1) hd = sq1.pop_front();
          else hd = sq0.pop_front();
          chk("flt_in_din", flt_in_din, hd);
        end
        fq.push_back(flt_in_din);
        if (in_pix == 4 * NP && g5_cyc < 0) g5_cyc = cyc;
        if (in_pix % NP == 0) cur_fsrc = s;
        else chk("no_interleave", s, cur_fsrc);
        in_pix++;
        if (in_pix % NP == 0) frame_src_log.push_back(cur_fsrc);
      end else begin
        chk("flt_in_din_idle", flt_in_din, 0);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    sq0.delete(); sq1.delete(); fq.delete(); exp0.delete(); exp1.delete();
    frame_src_log.delete();
    in_pix = 0; rx0 = 0; rx1 = 0; pop_cyc = -1; g5_cyc = -1; fifo_hit_full = 0;
    dst0_full = 1'b0; dst1_full = 1'b0; fcap = 64;
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
  endtask

  task automatic load(input int src, input int n);
    logic [7:0] v;
    @(posedge clock); #2;
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < NP; p++) begin
        v = 8'(src * 128 + k * 16 + p + 1);
        if (src == 0) begin sq0.push_back(v); exp0.push_back(v); end
        else begin sq1.push_back(v); exp1.push_back(v); end
      end
    end
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clock); #1;
      if (sq0.size() == 0 && sq1.size() == 0 && fq.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("drain_timeout");
  endtask

  task automatic check_order(input int f0, input int f1);
    int eo[$];
    int last, r0, r1, g;
    last = 1; r0 = f0; r1 = f1;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) g = 1 - last;
      else g = (r0 > 0) ? 0 : 1;
      eo.push_back(g);
      last = g;
      if (g == 0) r0--; else r1--;
    end
    chk("grant_count", frame_src_log.size(), eo.size());
    for (int i = 0; i < eo.size() && i < frame_src_log.size(); i++)
      chk("grant_order", frame_src_log[i], eo[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    src0_empty = 1'b1; src1_empty = 1'b1; src0_dout = 8'h00; src1_dout = 8'h00;
    flt_in_full = 1'b0; flt_out_empty = 1'b1; flt_out_dout = 8'h00;
    dst0_full = 1'b0; dst1_full = 1'b0;

    vecs[0] = '{1, 0, 12, 0, 0};
    vecs[1] = '{1, 1, 12, 12, 0};
    vecs[2] = '{3, 3, 36, 36, 0};
    vecs[3] = '{0, 2, 0, 24, 1};
    vecs[4] = '{2, 1, 24, 12, 0};

    #12;
    chk("rst_src_rd", {src0_rd_en, src1_rd_en}, 0);
    chk("rst_flt_wr", flt_in_wr_en, 0);
    chk("rst_flt_rd", flt_out_rd_en, 0);
    chk("rst_dst_wr", {dst0_wr_en, dst1_wr_en}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_src", cur_src, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      if (vecs[i].f0 > 0) load(0, vecs[i].f0);
      if (vecs[i].f1 > 0) load(1, vecs[i].f1);
      drain(2000);
      chk("vec_rx0", rx0, vecs[i].exp_rx0);
      chk("vec_rx1", rx1, vecs[i].exp_rx1);
      chk("vec_left0", exp0.size(), 0);
      chk("vec_left1", exp1.size(), 0);
      chk("vec_busy_fall", cyc - last_wr_cyc, 1);
      if (frame_src_log.size() > 0) chk("vec_first_grant", frame_src_log[0], vecs[i].exp_first);
      else fail_now("vec_no_grant");
      check_order(vecs[i].f0, vecs[i].f1);
`ifdef FILTER_FRAME_ARB_STATS_EN
      chk("vec_frames_done0", frames_done0, vecs[i].f0);
      chk("vec_frames_done1", frames_done1, vecs[i].f1);
`endif
    end

    // Destination 1 stalled while its frame sits at the filter output.
    do_reset();
    fcap = 20;
    dst1_full = 1'b1;
    load(0, 1);
    load(1, 2);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock); #1;
      if (i >= 25) chk("stall_no_out_rd", flt_out_rd_en, 0);
    end
    chk("stall_rx0", rx0, 12);
    chk("stall_rx1", rx1, 0);
    chk("stall_hit_full", fifo_hit_full, 1);
    chk("stall_in_pix", in_pix, 32);
    @(posedge clock); #2 dst1_full = 1'b0;
    drain(2000);
    chk("stall_rx1_after", rx1, 24);
    chk("stall_left1", exp1.size(), 0);
    check_order(1, 2);

    // Tag FIFO full: four frames in flight, fifth grant waits for the first pop.
    do_reset();
    fcap = 100;
    dst0_full = 1'b1;
    load(0, 6);
    repeat (120) @(negedge clock);
    #1;
    chk("tagfull_in_pix", in_pix, 48);
    chk("tagfull_grants", frame_src_log.size(), 4);
    chk("tagfull_busy", busy, 1);
    @(posedge clock); #2 dst0_full = 1'b0;
    drain(2000);
    chk("tagfull_regrant_latency", g5_cyc - pop_cyc, 2);
    chk("tagfull_rx0", rx0, 72);
    chk("tagfull_left0", exp0.size(), 0);

    // Reset in the middle of a frame.
    do_reset();
    load(0, 1);
    load(1, 1);
    for (int t = 0; t < 200; t++) begin
      @(posedge clock);
      if (in_pix >= 5) break;
    end
    chk("midrst_in_pix", in_pix, 5);
    #2 reset = 1'b1;
    #1;
    chk("midrst_src_rd", {src0_rd_en, src1_rd_en}, 0);
    chk("midrst_flt", {flt_in_wr_en, flt_out_rd_en}, 0);
    chk("midrst_dst_wr", {dst0_wr_en, dst1_wr_en}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cur_src", cur_src, 0);
`ifdef FILTER_FRAME_ARB_STATS_EN
    chk("midrst_frames_done0", frames_done0, 0);
    chk("midrst_frames_done1", frames_done1, 0);
`endif
    do_reset();
    load(0, 1);
    load(1, 1);
    drain(2000);
    check_order(1, 1);
    chk("midrst_rx0", rx0, 12);
    chk("midrst_rx1", rx1, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
